// File: rtl/out_drain_ctrl_if.sv
// -----------------------------------------------------------------------------
// out_drain_ctrl_if
// Bundles the drain request and output-memory write signals of out_drain_ctrl.
//
// Signals:
//   start      request to drain one result tile
//   base_addr  output-memory row address for result row 0
//   num_rows   rows per tile (only with OUT_DRAIN_ROWCOUNT_EN defined)
//   wr_en      per-bank write enable, bit c drives bank c
//   wr_addr    per-bank write address, bits [8c+7:8c] belong to bank c
//   busy       high while a drain is in progress
//   done       single-cycle completion pulse
//
// Modports:
//   master  requester side (drives start/base_addr/num_rows)
//   slave   drain controller side
//
// Optional feature macro: OUT_DRAIN_ROWCOUNT_EN (adds num_rows).
// -----------------------------------------------------------------------------
interface out_drain_ctrl_if #(
    parameter int WIDTH_HEIGHT = 16
);
    logic                      start;
    logic [7:0]                base_addr;
`ifdef OUT_DRAIN_ROWCOUNT_EN
    logic [7:0]                num_rows;
`endif
    logic [WIDTH_HEIGHT-1:0]   wr_en;
    logic [WIDTH_HEIGHT*8-1:0] wr_addr;
    logic                      busy;
    logic                      done;

`ifdef OUT_DRAIN_ROWCOUNT_EN
    modport master (
        output start, base_addr, num_rows,
        input  wr_en, wr_addr, busy, done
    );
    modport slave (
        input  start, base_addr, num_rows,
        output wr_en, wr_addr, busy, done
    );
`else
    modport master (
        output start, base_addr,
        input  wr_en, wr_addr, busy, done
    );
    modport slave (
        input  start, base_addr,
        output wr_en, wr_addr, busy, done
    );
`endif
endinterface

// File: rtl/out_drain_ctrl.sv
// -----------------------------------------------------------------------------
// out_drain_ctrl
// Drains one result tile from an N x N systolic array into N output-memory
// banks. Results leave the array skewed by one cycle per column, so bank c
// writes rows 0..R-1 starting c cycles after bank 0.
//
// Parameters:
//   WIDTH_HEIGHT  array dimension N (columns = rows = banks)
//   LATENCY       cycles from accepted start to the first valid result (1..255)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    out_drain_ctrl_if.slave: start, base_addr, [num_rows],
//          wr_en, wr_addr, busy, done
//
// Optional feature macro: OUT_DRAIN_ROWCOUNT_EN
//   Adds num_rows (latched with start). R = num_rows for 1..N, otherwise N.
//   Without the macro R = N.
//
// All outputs are registered; they are loaded from the next-state values so
// the first write lands exactly LATENCY cycles after the accepted start.
// -----------------------------------------------------------------------------
module out_drain_ctrl #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int LATENCY      = 16
) (
    input  logic             clk,
    input  logic             reset,
    out_drain_ctrl_if.slave  bus
);

    // Counter must cover both the WAIT phase (up to 253) and k up to 2N-2.
    localparam int K_W   = $clog2(2 * WIDTH_HEIGHT);
    localparam int CNT_W = (K_W > 8) ? K_W : 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic [7:0]                base_r;
    logic [7:0]                base_nxt_s;
    logic                      accept_s;
    logic [CNT_W-1:0]          rows_s;
    logic [CNT_W-1:0]          rows_nxt_s;
    logic                      wait_last_s;
    logic                      drain_last_s;
    logic [WIDTH_HEIGHT-1:0]   wr_en_r;
    logic [WIDTH_HEIGHT-1:0]   wr_en_nxt_s;
    logic [WIDTH_HEIGHT*8-1:0] wr_addr_r;
    logic [WIDTH_HEIGHT*8-1:0] wr_addr_nxt_s;
    logic                      busy_r;
    logic                      done_r;

    // Bank c is enabled at drain count k iff c <= k < c + rows.
    function automatic logic bank_active(input logic [CNT_W-1:0] k,
                                         input int               c,
                                         input logic [CNT_W-1:0] rows);
        int k_i;
        k_i = int'(k);
        return (k_i >= c) && (k_i < (c + int'(rows)));
    endfunction

    // Row r = k - c lands at base + r, wrapping modulo 256.
    function automatic logic [7:0] bank_addr(input logic [7:0]       base,
                                             input logic [CNT_W-1:0] k,
                                             input int               c);
        int r_i;
        r_i = int'(k) - c;
        return base + r_i[7:0];
    endfunction

`ifdef OUT_DRAIN_ROWCOUNT_EN
    logic [CNT_W-1:0] rows_r;
    logic [CNT_W-1:0] rows_req_s;

    // Clamp the requested row count: 0 or anything above N means a full tile.
    always_comb begin
        rows_req_s = CNT_W'(WIDTH_HEIGHT);
        if ((bus.num_rows == 8'd0) || (int'(bus.num_rows) > WIDTH_HEIGHT)) begin
            rows_req_s = CNT_W'(WIDTH_HEIGHT);
        end else begin
            rows_req_s = CNT_W'(bus.num_rows);
        end
    end

    // Row count is captured together with the base address on an accepted start.
    always_comb begin
        rows_s     = rows_r;
        rows_nxt_s = rows_r;
        if (accept_s) begin
            rows_nxt_s = rows_req_s;
        end else begin
            rows_nxt_s = rows_r;
        end
    end

    // Row-count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_r <= {CNT_W{1'b0}};
        end else begin
            rows_r <= rows_nxt_s;
        end
    end
`else
    // Fixed full-tile row count.
    always_comb begin
        rows_s     = CNT_W'(WIDTH_HEIGHT);
        rows_nxt_s = CNT_W'(WIDTH_HEIGHT);
    end
`endif

    // Terminal counts for the WAIT and DRAIN phases.
    always_comb begin
        wait_last_s  = (cnt_r == CNT_W'(LATENCY - 2));
        drain_last_s = (cnt_r == (CNT_W'(WIDTH_HEIGHT) + rows_s - CNT_W'(2'd2)));
    end

    // Next-state, counter and base-address logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        base_nxt_s  = base_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s   = 1'b1;
                    base_nxt_s = bus.base_addr;
                    cnt_nxt_s  = {CNT_W{1'b0}};
                    // With LATENCY of 1 there are no WAIT cycles at all.
                    if (LATENCY == 1) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_last_s) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_DRAIN: begin
                if (drain_last_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Deskewed per-bank enables and addresses for the next cycle; idle banks hold.
    always_comb begin
        wr_en_nxt_s   = {WIDTH_HEIGHT{1'b0}};
        wr_addr_nxt_s = wr_addr_r;
        for (int c = 0; c < WIDTH_HEIGHT; c++) begin
            if ((state_nxt_s == ST_DRAIN) && bank_active(cnt_nxt_s, c, rows_nxt_s)) begin
                wr_en_nxt_s[c]          = 1'b1;
                wr_addr_nxt_s[8*c +: 8] = bank_addr(base_nxt_s, cnt_nxt_s, c);
            end else begin
                wr_en_nxt_s[c] = 1'b0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            base_r    <= 8'd0;
            wr_en_r   <= {WIDTH_HEIGHT{1'b0}};
            wr_addr_r <= {(WIDTH_HEIGHT*8){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            base_r    <= base_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule
